// File: rtl/axis_arb_pkg.sv
// Shared definitions for the packet round-robin AXIS arbiter: FSM encoding,
// width helper and the round-robin search function.
package axis_arb_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Upper bound on ports; rr_pick works on vectors padded to this width.
    localparam int MAX_PORTS = 16;

    // Ceiling log2 for constant width derivation (clog2(1) = 0).
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // First set bit of valid_vec searching ptr+1, ptr+2, ... modulo num.
    // Returns 0 when nothing is set; callers gate on |valid_vec.
    function automatic logic [3:0] rr_pick(input logic [MAX_PORTS-1:0] valid_vec,
                                           input logic [3:0]           ptr,
                                           input int                   num);
        logic [3:0] pick;
        logic       found;
        int         idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= MAX_PORTS; i++) begin
            idx = (int'(ptr) + i) % num;
            if (!found && (i <= num) && valid_vec[idx]) begin
                pick  = 4'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/axis_arb_skid_buffer.sv
// Two-entry valid/ready register slice. Outputs come straight from flops,
// and input ready is a flop meaning "the overflow entry is empty".
module axis_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [W-1:0] main_data_reg, main_data_next;
    logic         main_valid_reg, main_valid_next;
    logic [W-1:0] skid_data_reg, skid_data_next;
    logic         skid_valid_reg, skid_valid_next;
    logic         ready_reg;
    logic         in_fire;

    assign in_fire   = in_valid & ready_reg;
    assign in_ready  = ready_reg;
    assign out_data  = main_data_reg;
    assign out_valid = main_valid_reg;

    // Refill the output entry when it drains, otherwise park the beat in the overflow entry.
    always_comb begin
        main_data_next  = main_data_reg;
        main_valid_next = main_valid_reg;
        skid_data_next  = skid_data_reg;
        skid_valid_next = skid_valid_reg;
        if (!main_valid_reg || out_ready) begin
            if (skid_valid_reg) begin
                // Overflow entry drains first; ready is low so no new beat arrives.
                main_valid_next = 1'b1;
                main_data_next  = skid_data_reg;
                skid_valid_next = 1'b0;
            end else begin
                main_valid_next = in_fire;
                if (in_fire) begin
                    main_data_next = in_data;
                end
            end
        end else if (in_fire) begin
            skid_valid_next = 1'b1;
            skid_data_next  = in_data;
        end
    end

    // Control state with reset; ready tracks the next overflow occupancy.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
            ready_reg      <= 1'b1;
        end else begin
            main_valid_reg <= main_valid_next;
            skid_valid_reg <= skid_valid_next;
            ready_reg      <= !skid_valid_next;
        end
    end

    // Payload registers need no reset; they are qualified by the valid flags.
    always_ff @(posedge clk) begin
        main_data_reg <= main_data_next;
        skid_data_reg <= skid_data_next;
    end

endmodule

// File: rtl/axis_packet_rr_arbiter.sv
// Packet-atomic round-robin merge of NUM_PORTS AXIS sources into one stream,
// tagging each beat with its source index and counting completed packets.
module axis_packet_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int DW        = 128,
    parameter int IDW       = clog2(NUM_PORTS)
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NUM_PORTS*DW-1:0]   s_axis_tdata,
    input  logic [NUM_PORTS*DW/8-1:0] s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]      s_axis_tlast,
    input  logic [NUM_PORTS-1:0]      s_axis_tvalid,
    output logic [NUM_PORTS-1:0]      s_axis_tready,
    output logic [DW-1:0]             m_axis_tdata,
    output logic [DW/8-1:0]           m_axis_tkeep,
    output logic                      m_axis_tlast,
    output logic [IDW-1:0]            m_axis_tid,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [NUM_PORTS-1:0]      grant,
    output logic [31:0]               pkt_count
);

    localparam int KW = DW / 8;
    localparam int SW = IDW + 1 + KW + DW;

    logic [0:0]           state_reg, state_next;
    logic [NUM_PORTS-1:0] grant_reg, grant_next;
    logic [IDW-1:0]       sel_reg, sel_next;
    logic [IDW-1:0]       rr_ptr_reg, rr_ptr_next;
    logic [31:0]          pkt_count_reg;

    logic [DW-1:0]        sel_data;
    logic [KW-1:0]        sel_keep;
    logic                 sel_last;
    logic                 sel_valid;
    logic                 granted;
    logic                 skid_in_valid;
    logic                 skid_in_ready;
    logic                 s_fire;
    logic [SW-1:0]        skid_out;
    logic [MAX_PORTS-1:0] valid_pad;
    logic [3:0]           pick;

    assign granted       = (state_reg == ST_GRANT);
    assign sel_data      = s_axis_tdata[sel_reg*DW +: DW];
    assign sel_keep      = s_axis_tkeep[sel_reg*KW +: KW];
    assign sel_last      = s_axis_tlast[sel_reg];
    assign sel_valid     = s_axis_tvalid[sel_reg];
    assign skid_in_valid = granted & sel_valid;
    assign s_fire        = skid_in_valid & skid_in_ready;
    assign grant         = grant_reg;
    assign pkt_count     = pkt_count_reg;

    // Only the owning port ever sees ready; everyone else is left waiting.
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_ready
            assign s_axis_tready[gi] = granted && (sel_reg == IDW'(gi)) && skid_in_ready;
        end
    endgenerate

    // Arbitration: pick the next requester after rr_ptr, then hold it until its tlast.
    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        sel_next    = sel_reg;
        rr_ptr_next = rr_ptr_reg;
        valid_pad   = '0;
        valid_pad[NUM_PORTS-1:0] = s_axis_tvalid;
        pick        = rr_pick(valid_pad, 4'(rr_ptr_reg), NUM_PORTS);
        case (state_reg)
            ST_IDLE: begin
                if (|s_axis_tvalid) begin
                    grant_next = NUM_PORTS'(1) << pick;
                    sel_next   = IDW'(pick);
                    state_next = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // The pointer moves only at packet end, so order ignores packet length.
                if (s_fire && sel_last) begin
                    grant_next  = '0;
                    rr_ptr_next = sel_reg;
                    state_next  = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                grant_next = '0;
            end
        endcase
    end

    // Arbiter state; reset leaves port 0 first in line.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg  <= ST_IDLE;
            grant_reg  <= '0;
            sel_reg    <= '0;
            rr_ptr_reg <= IDW'(NUM_PORTS - 1);
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            sel_reg    <= sel_next;
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    // Count packets as their final beat leaves on the m side.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pkt_count_reg <= '0;
        end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            pkt_count_reg <= pkt_count_reg + 32'd1;
        end
    end

    axis_skid_buffer #(
        .W(SW)
    ) u_skid (
        .clk       (clk),
        .resetn    (resetn),
        .in_data   ({sel_reg, sel_last, sel_keep, sel_data}),
        .in_valid  (skid_in_valid),
        .in_ready  (skid_in_ready),
        .out_data  (skid_out),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready)
    );

    assign {m_axis_tid, m_axis_tlast, m_axis_tkeep, m_axis_tdata} = skid_out;

endmodule

// File: doc/axis_packet_rr_arbiter.md
Name: axis_packet_rr_arbiter

Overview:
Merges NUM_PORTS packet-headered AXI-Stream sources into one AXIS output. The sources are length-prepending packet streams, each carrying one header beat followed by its packet. Arbitration is round-robin and packet-atomic: once a port is granted, it keeps the output until its tlast beat is accepted. The block sits between several packet-length-header stages and the shared downstream consumer (DMA/Ethernet TX). Its output passes through a full-throughput skid register.

Parameters:
NUM_PORTS, 4, number of input streams (2..16)
DW, 128, tdata width in bits (multiple of 8)
IDW, 2, tid width; must equal ceil(log2(NUM_PORTS)) and be at least 1

Ports:
clk  in  1  clock
resetn  in  1  synchronous, active-low reset
s_axis_tdata  in  NUM_PORTS*DW  input data; port p occupies bits [p*DW +: DW]
s_axis_tkeep  in  NUM_PORTS*DW/8  input byte enables, packed the same way
s_axis_tlast  in  NUM_PORTS  per-port end of packet
s_axis_tvalid  in  NUM_PORTS  per-port valid
s_axis_tready  out  NUM_PORTS  per-port ready
m_axis_tdata  out  DW  merged data
m_axis_tkeep  out  DW/8  merged byte enables
m_axis_tlast  out  1  merged end of packet
m_axis_tid  out  IDW  source port index of the current beat
m_axis_tvalid  out  1  merged valid
m_axis_tready  in  1  downstream ready
grant  out  NUM_PORTS  one-hot, registered; current owner; all zeros when idle
pkt_count  out  32  packets completed on the m side; wraps modulo 2^32

Behaviour:
- Reset (resetn=0 at a clk edge):
  - state=IDLE, grant=0, rr_ptr=NUM_PORTS-1 (port 0 wins first), pkt_count=0, skid emptied.
  - m_axis_tvalid=0 and s_axis_tready=0 from the following cycle.
  - m_axis_tdata/tkeep/tlast/tid are don't-care while tvalid=0.
- FSM states: IDLE, GRANT.
- IDLE:
  - If any s_axis_tvalid is set, pick the first requesting port p, searching rr_ptr+1, rr_ptr+2, ... modulo NUM_PORTS.
  - Register grant=onehot(p) and sel=p, then move to GRANT. This costs one arbitration cycle.
  - All s_axis_tready stay 0 while in IDLE.
- GRANT:
  - s_axis_tready[sel] = skid input ready; every other tready is 0.
  - A beat transfers on s_axis_tvalid[sel] & s_axis_tready[sel], and enters the skid tagged tid=sel.
  - When the transferred beat has tlast=1: rr_ptr<=sel, grant<=0, next state IDLE.
- Non-granted ports are never acknowledged, no matter what their tvalid does.
- A stalled granted port (tvalid=0 mid-packet) holds the grant indefinitely. There is no timeout.
- Packet gap: the next packet's first beat can be accepted at the earliest 2 cycles after the previous tlast is accepted (one IDLE cycle, then GRANT).
- Fairness: with all ports requesting continuously, packets go out in order 0,1,2,...,N-1,0,... Sequence is set by rr_ptr update, not packet length.
- Skid buffer:
  - Two entries, registered outputs, 1-cycle latency from s acceptance to m_axis_tvalid.
  - Sustains 1 beat/cycle while m_axis_tready=1.
  - Input ready is registered, taken as "second entry empty".
  - While m_axis_tvalid=1 and m_axis_tready=0, all m_axis_* outputs hold stable.
- pkt_count increments by 1 on every m_axis_tvalid & m_axis_tready & m_axis_tlast.
- A single-beat packet (header beat with tlast=1) is legal. Grant lasts one transfer.
- Reset mid-packet: the packet in flight is abandoned with no flush and no tlast insertion. The skid is cleared.

Decomposition:
- Shared package axis_arb_pkg holds:
  - FSM state encoding (IDLE=0, GRANT=1).
  - A constant function clog2 for deriving IDW.
  - A round-robin next-index function rr_pick(valid_vec, ptr).
- One sub-module: axis_skid_buffer (params W), a 2-entry valid/ready register slice.
  - It carries {tid, tlast, tkeep, tdata} as a single W-bit bus.

Test Plan:
1. Port 0 alone sends a 3-beat packet while m_axis_tready=1.
   - Expect s_axis_tready[0]=1 from cycle 2 after tvalid rises.
   - m side shows 3 beats with tid=0 and tlast on beat 3.
   - pkt_count=1 and grant returns to 0.
2. All 4 ports hold a 2-beat packet ready continuously.
   - Output tid order is 0,1,2,3,0.
   - Exactly 1 idle cycle between packets on the s side.
3. Port 2 is granted mid-packet while port 1 asserts tvalid.
   - s_axis_tready[1] stays 0 until port 2's tlast is accepted.
   - Port 1 is granted next.
4. m_axis_tready toggles 1,0,0,1 during a 5-beat packet.
   - No beat is lost or duplicated.
   - m_axis_* stay stable during every stall.
   - Beat data arrives in order.
5. Port 3 sends a single-beat packet (tlast=1, tkeep=16'hFFFF, data=0x0040).
   - One m beat appears with tid=3, tlast=1, data 0x0040.
6. Reset is asserted on beat 2 of a 4-beat packet from port 1.
   - The next cycle shows m_axis_tvalid=0, grant=0, pkt_count=0.
   - A new port 0 packet after reset is granted first.
